led_seq_ctrl: RTL and testbench

- Command-driven sequencer for the 8-bit LED counter datapath of the example designs.
- Accepts load, count-up, count-down and hold commands over a valid/ready handshake.
- Steps the counter at a prescaled rate and reports completion.
- Sits between a simple host or stimulus source and the board LED pins, replacing the free-running counter.

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_seq_ctrl.sv | 105 ++++++++++
 tb/tb_led_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and defaults for the LED sequencer.
// Opcodes, controller states and default widths.
package led_seq_pkg;

  localparam int LED_W = 8;
  localparam int LEN_W_DEF = 10;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_HOLD = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } st_e;

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler producing one tick every DIV+1 enabled clocks.
// clear restarts the count and has priority over en.
module led_tick_gen #(
  parameter int DIV = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == TOP);
  assign tick   = en && at_top;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// Command-driven LED counter sequencer.
// Load/up/down/hold commands, prescaled stepping, done pulse.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int WIDTH = LED_W,
  parameter int DIV   = 0,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic [WIDTH-1:0] leds,
  output logic             busy,
  output logic             done
);

  st_e              state_q;
  op_e              op_q;
  op_e              op_in;
  logic [LEN_W-1:0] rem_q;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             done_q;
  logic             accept;
  logic             running;
  logic             tick;
  logic             last;

  assign op_in     = op_e'(cmd_op);
  assign running   = (state_q == ST_RUN);
  assign cmd_ready = (state_q == ST_IDLE) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign last      = (rem_q == LEN_W'(1));

  assign leds = leds_q;
  assign busy = running;
  assign done = done_q;

  led_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (running),
    .clear(accept || abort),
    .tick (tick)
  );

  always_comb begin
    leds_d = leds_q;
    unique case (op_q)
      OP_UP:   leds_d = leds_q + WIDTH'(1);
      OP_DOWN: leds_d = leds_q - WIDTH'(1);
      default: leds_d = leds_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      rem_q   <= '0;
      leds_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op_in == OP_LOAD) begin
              leds_q <= cmd_data;
              done_q <= 1'b1;
            end else if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              rem_q   <= cmd_len;
              op_q    <= op_in;
            end
          end
        end
        ST_RUN: begin
          // abort freezes leds even when a tick lands on the same edge
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (tick) begin
            leds_q <= leds_d;
            rem_q  <= rem_q - LEN_W'(1);
            if (last) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: DIV=0 and DIV=3 instances.
// Directed plan followed by random commands against a step model.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] valid = '0;
  logic [1:0] abrt = '0;
  logic [1:0] ready, busy, done;
  logic [1:0][7:0] leds;
  op_e  cop = OP_LOAD;
  logic [7:0] cdata = '0;
  logic [9:0] clen = '0;

  int vec = 0;
  int miss = 0;
  logic [7:0] mleds [2];

  always #5 clk = ~clk;

  led_seq_ctrl #(.WIDTH(8), .DIV(0), .LEN_W(10)) u_d0 (
    .clk(clk), .rst(rst),
    .cmd_valid(valid[0]), .cmd_ready(ready[0]),
    .cmd_op(cop), .cmd_data(cdata), .cmd_len(clen),
    .abort(abrt[0]), .leds(leds[0]),
    .busy(busy[0]), .done(done[0])
  );

  led_seq_ctrl #(.WIDTH(8), .DIV(3), .LEN_W(10)) u_d3 (
    .clk(clk), .rst(rst),
    .cmd_valid(valid[1]), .cmd_ready(ready[1]),
    .cmd_op(cop), .cmd_data(cdata), .cmd_len(clen),
    .abort(abrt[1]), .leds(leds[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] s,
                                       input op_e op, input int k);
    case (op)
      OP_UP:   return s + 8'(k);
      OP_DOWN: return s - 8'(k);
      default: return s;
    endcase
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  // ab: cycle index after accept at which abort is raised (-1 = none)
  task automatic do_cmd(input int w, input op_e op, input logic [7:0] data,
                        input int len, input int ab);
    int d, n, st;
    logic [7:0] s;
    bit fin;
    d = (w == 1) ? 4 : 1;
    s = mleds[w];
    chk("ready_pre", 32'(ready[w]), 1);
    cop = op;
    cdata = data;
    clen = 10'(len);
    valid[w] = 1'b1;
    tick1();
    valid[w] = 1'b0;
    if (op == OP_LOAD || len == 0) begin
      if (op == OP_LOAD) mleds[w] = data;
      chk("imm_leds", 32'(leds[w]), 32'(mleds[w]));
      chk("imm_done", 32'(done[w]), 1);
      chk("imm_busy", 32'(busy[w]), 0);
      chk("imm_ready", 32'(ready[w]), 1);
      tick1();
      chk("imm_done_off", 32'(done[w]), 0);
      return;
    end
    fin = 0;
    n = 0;
    while (!fin) begin
      st = (n / d < len) ? n / d : len;
      chk("run_leds", 32'(leds[w]), 32'(model(s, op, st)));
      chk("run_busy", 32'(busy[w]), 32'(st < len));
      chk("run_ready", 32'(ready[w]), 32'(st >= len));
      chk("run_done", 32'(done[w]), 32'(n == len * d));
      if (n == ab) begin
        abrt[w] = 1'b1;
        #1;
        chk("ab_ready_lo", 32'(ready[w]), 0);
        tick1();
        abrt[w] = 1'b0;
        #1;
        mleds[w] = model(s, op, st);
        chk("ab_leds", 32'(leds[w]), 32'(mleds[w]));
        chk("ab_busy", 32'(busy[w]), 0);
        chk("ab_done", 32'(done[w]), 0);
        chk("ab_ready", 32'(ready[w]), 1);
        tick1();
        chk("ab_done2", 32'(done[w]), 0);
        chk("ab_leds2", 32'(leds[w]), 32'(mleds[w]));
        fin = 1;
      end else if (n == len * d + 1) begin
        mleds[w] = model(s, op, len);
        fin = 1;
      end else begin
        tick1();
        n++;
      end
    end
  endtask

  initial begin
    int w, len, ab, d;
    op_e op;
    mleds[0] = 8'h00;
    mleds[1] = 8'h00;
    #1;
    chk("rst_leds", 32'(leds[0]), 0);
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_done", 32'(done[0]), 0);
    chk("rst_ready", 32'(ready[0]), 1);
    chk("rst_leds3", 32'(leds[1]), 0);
    repeat (5) tick1();
    rst = 1'b0;
    tick1();

    do_cmd(0, OP_LOAD, 8'hA5, 0, -1);
    do_cmd(0, OP_LOAD, 8'h00, 0, -1);
    do_cmd(0, OP_UP, 8'h00, 500, -1);
    chk("up500_final", 32'(leds[0]), 32'hF4);
    do_cmd(0, OP_LOAD, 8'h01, 0, -1);
    do_cmd(0, OP_DOWN, 8'h00, 3, -1);
    chk("down3_final", 32'(leds[0]), 32'hFE);
    do_cmd(0, OP_HOLD, 8'h00, 4, -1);
    do_cmd(0, OP_UP, 8'h00, 0, -1);
    chk("up0_final", 32'(leds[0]), 32'hFE);

    do_cmd(1, OP_LOAD, 8'h00, 0, -1);
    do_cmd(1, OP_UP, 8'h00, 2, -1);
    chk("div3_final", 32'(leds[1]), 32'h02);

    do_cmd(0, OP_LOAD, 8'h10, 0, -1);
    do_cmd(0, OP_UP, 8'h00, 10, 2);
    chk("abort_frozen", 32'(leds[0]), 32'h12);

    abrt[0] = 1'b1;
    valid[0] = 1'b1;
    cop = OP_LOAD;
    cdata = 8'hEE;
    #1;
    chk("idle_ab_ready", 32'(ready[0]), 0);
    tick1();
    abrt[0] = 1'b0;
    valid[0] = 1'b0;
    #1;
    chk("idle_ab_leds", 32'(leds[0]), 32'h12);
    chk("idle_ab_done", 32'(done[0]), 0);

    cop = OP_UP;
    clen = 10'd50;
    valid[0] = 1'b1;
    tick1();
    valid[0] = 1'b0;
    repeat (5) tick1();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_leds", 32'(leds[0]), 0);
    chk("arst_busy", 32'(busy[0]), 0);
    chk("arst_ready", 32'(ready[0]), 1);
    chk("arst_done", 32'(done[0]), 0);
    tick1();
    rst = 1'b0;
    mleds[0] = 8'h00;
    mleds[1] = 8'h00;
    tick1();
    chk("post_rst_done", 32'(done[0]), 0);
    do_cmd(0, OP_LOAD, 8'h3C, 0, -1);

    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 1));
      d = (w == 1) ? 4 : 1;
      op = op_e'($urandom_range(0, 3));
      len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      ab = -1;
      if (op != OP_LOAD && len > 0 && $urandom_range(0, 3) == 0)
        ab = int'($urandom_range(0, len * d - 1));
      do_cmd(w, op, 8'($urandom), len, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
